loopback_fifo: RTL and testbench

LOOPBACK_FIFO -- requirements
Module: loopback_fifo

---
 rtl/loopback_pkg.sv | 14 +
 rtl/loopback_fifo_mem.sv | 34 +++
 rtl/loopback_fifo.sv | 71 +++++++
 tb/tb_loopback_fifo.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/loopback_pkg.sv
// loopback_pkg: shared MODE encoding and send-FSM state enums for the loopback FIFO
package loopback_pkg;
  typedef enum logic [1:0] {
    MODE_ECHO = 2'b00,
    MODE_INV  = 2'b01,
    MODE_INC  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/loopback_fifo_mem.sv
// loopback_fifo_mem: DEPTH x DATA_W register FIFO with wrapping pointers.
//   clk/rst: clock and sync active-high reset
//   wr_en/wr_data: push; rd_en: pop head; rd_data: current head; count: occupancy
module loopback_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/loopback_fifo.sv
// loopback_fifo: buffers received bytes, transforms them by MODE, and hands them to a sender.
//   CLK/RST: clock, sync active-high reset
//   RX_DATA/RX_VALID: incoming byte; MODE: 00 echo, 01 invert, 10 increment, 11 hold
//   SEND_DATA/SEND_START/SEND_DONE: sender handshake
//   COUNT: FIFO occupancy; OVERFLOW: sticky drop flag
//   DROP_CNT: saturating drop counter, present only with LOOPBACK_DROP_COUNT_EN
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_W-1:0]      RX_DATA,
  input  logic                   RX_VALID,
  input  logic [1:0]             MODE,
  output logic [DATA_W-1:0]      SEND_DATA,
  output logic                   SEND_START,
  input  logic                   SEND_DONE,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW
`ifdef LOOPBACK_DROP_COUNT_EN
  ,
  output logic [15:0]            DROP_CNT
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state, state_nx;
  logic [DATA_W-1:0] wr_data, head;
  logic full, wr_en, pop, drop;
  // full is judged on the registered count, so a same-cycle pop never frees room for a write
  assign full       = COUNT == CW'(DEPTH);
  assign wr_en      = RX_VALID && !full;
  assign drop       = RX_VALID && full;
  assign pop        = state == ST_START;
  assign SEND_START = pop;
  always_comb begin
    wr_data  = MODE == MODE_INV ? ~RX_DATA : MODE == MODE_INC ? RX_DATA + DATA_W'(1) : RX_DATA;
    state_nx = state == ST_IDLE  ? ((COUNT != '0 && MODE != MODE_HOLD) ? ST_START : ST_IDLE) :
               state == ST_START ? ST_WAIT :
               SEND_DONE         ? ST_IDLE : ST_WAIT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      SEND_DATA <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      state <= state_nx;
      // latch the head on entry to START so it is valid during SEND_START and held until the next one
      if (state == ST_IDLE && state_nx == ST_START) SEND_DATA <= head;
      if (drop) OVERFLOW <= 1'b1;
    end
  end
`ifdef LOOPBACK_DROP_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) DROP_CNT <= '0;
    else if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
  end
`endif
  loopback_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(head),
    .count  (COUNT)
  );
endmodule

// File: tb/tb_loopback_fifo.sv
// tb_loopback_fifo: directed and random checks of loopback_fifo against a queue-based reference
module tb_loopback_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic CLK = 1'b0, RST = 1'b1, RX_VALID = 1'b0, SEND_DONE = 1'b0;
  logic [DW-1:0] RX_DATA = '0;
  logic [1:0] MODE = 2'b00;
  logic [DW-1:0] SEND_DATA;
  logic SEND_START, OVERFLOW;
  logic [$clog2(DEPTH):0] COUNT;
`ifdef LOOPBACK_DROP_COUNT_EN
  logic [15:0] DROP_CNT;
`endif
  loopback_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .MODE(MODE),
    .SEND_DATA(SEND_DATA), .SEND_START(SEND_START), .SEND_DONE(SEND_DONE),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW)
`ifdef LOOPBACK_DROP_COUNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  bit ovf, waiting, prev_idle;
  int prev_cnt, prev_mode, drops, last_sent, starts;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int xform(int m, int d);
    int lim = 1 << DW;
    return m == 1 ? (lim - 1) - d : m == 2 ? (d + 1) % lim : d;
  endfunction
  task automatic step(bit v, int d, int m, bit done);
    bit busy;
    chk("send_start", 32'(SEND_START), 32'(prev_idle && prev_cnt > 0 && prev_mode != 3));
    chk("count", 32'(COUNT), q.size());
    chk("overflow", 32'(OVERFLOW), 32'(ovf));
`ifdef LOOPBACK_DROP_COUNT_EN
    chk("drop_cnt", 32'(DROP_CNT), drops);
`endif
    if (SEND_START && q.size() > 0) begin
      chk("send_data_head", 32'(SEND_DATA), q[0]);
      last_sent = q[0];
      starts++;
    end else chk("send_data_hold", 32'(SEND_DATA), last_sent);
    RX_VALID = v; RX_DATA = DW'(d); MODE = 2'(m); SEND_DONE = done;
    busy = SEND_START || waiting;
    prev_idle = !busy; prev_cnt = q.size(); prev_mode = m;
    if (v) begin
      if (q.size() < DEPTH) q.push_back(xform(m, d));
      else begin
        ovf = 1'b1;
        if (drops < 65535) drops++;
      end
    end
    if (SEND_START && q.size() > 0) void'(q.pop_front());
    waiting = SEND_START || (waiting && !done);
    @(posedge CLK); @(negedge CLK);
  endtask
  task automatic do_reset();
    RST = 1'b1; RX_VALID = 1'b0; SEND_DONE = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    q.delete(); ovf = 0; drops = 0; waiting = 0; prev_idle = 1; prev_cnt = 0; prev_mode = 0; last_sent = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && (q.size() > 0 || waiting); i++) step(0, 0, 0, waiting && ($urandom % 2 == 0));
    step(0, 0, 0, 0);
    chk("drain_count", 32'(COUNT), 0);
  endtask
  initial begin
    do_reset();
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_send_data", 32'(SEND_DATA), 0);
    chk("rst_send_start", 32'(SEND_START), 0);
    chk("rst_overflow", 32'(OVERFLOW), 0);
    step(1, 'h41, 0, 0);
    step(0, 0, 0, 0);
    chk("echo_latency", 32'(SEND_START), 1);
    chk("echo_data", 32'(SEND_DATA), 'h41);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 'h0F, 1, 0);
    step(0, 0, 1, 0);
    chk("inv_data", 32'(SEND_DATA), 'hF0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 'hFF, 2, 0);
    step(0, 0, 2, 0);
    chk("inc_wrap_data", 32'(SEND_DATA), 'h00);
    chk("inc_start", 32'(SEND_START), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 'h10 + i, 3, 0);
    step(0, 0, 3, 0);
    chk("ovf_count", 32'(COUNT), 16);
    chk("ovf_flag", 32'(OVERFLOW), 1);
`ifdef LOOPBACK_DROP_COUNT_EN
    chk("ovf_drop_cnt", 32'(DROP_CNT), 1);
`endif
    starts = 0;
    drain();
    chk("ovf_sent_count", starts, 16);
    do_reset();
    step(1, 'hA1, 0, 0);
    step(1, 'hA2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 3, 0);
    step(0, 0, 3, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 3, 0);
    chk("hold_count", 32'(COUNT), 1);
    chk("hold_no_start", 32'(SEND_START), 0);
    step(0, 0, 0, 0);
    chk("hold_release_start", 32'(SEND_START), 1);
    chk("hold_release_data", 32'(SEND_DATA), 'hA2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 'h30 + i, 3, 0);
    step(0, 0, 0, 0);
    chk("simul_start", 32'(SEND_START), 1);
    step(1, 'h77, 0, 0);
    chk("simul_count", 32'(COUNT), 3);
    drain();
    do_reset();
    step(1, 'h55, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    chk("rstw_send_data", 32'(SEND_DATA), 0);
    chk("rstw_send_start", 32'(SEND_START), 0);
    chk("rstw_count", 32'(COUNT), 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("rstw_no_start", 32'(SEND_START), 0);
    do_reset();
    begin
      int m = 0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom % 25 == 0) m = int'($urandom % 4);
        step($urandom % 3 == 0, int'($urandom % 256), m,
             waiting ? ($urandom % 3 == 0) : ($urandom % 10 == 0));
      end
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
